// File: rtl/data_mem_access_unit_if.sv
// rtl/data_mem_access_unit_if.sv - request/response and data-memory bus bundle for the load/store unit
interface data_mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Mem_Data;

  // the load/store unit: serves pipeline requests, drives the memory bus
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, Mem_Data,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, Mem_Read, Mem_Write, Address, Write_data
  );

  // the environment: pipeline issuing requests plus the data memory
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, Mem_Data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, Mem_Read, Mem_Write, Address, Write_data
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - load/store initiator for the byte-addressed big-endian data memory
module data_mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic                   clk,
  input logic                   reset_n,
  data_mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;   // store data, replaced by the merged word after RD
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [32:0] last_byte;
  logic        req_err;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] merged_byte;
  logic [31:0] merged_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // legality of the incoming request: size code, alignment, last touched byte in range
  always_comb begin
    last_byte = {1'b0, bus.req_addr};
    req_err   = 1'b0;
    case (bus.req_size)
      SZ_BYTE: last_byte = {1'b0, bus.req_addr};
      SZ_HALF: begin
        last_byte = {1'b0, bus.req_addr} + 33'd1;
        req_err   = bus.req_addr[0];
      end
      SZ_WORD: begin
        last_byte = {1'b0, bus.req_addr} + 33'd3;
        req_err   = |bus.req_addr[1:0];
      end
      default: req_err = 1'b1;
    endcase
    if (last_byte >= MEM_LIMIT) begin
      req_err = 1'b1;
    end
  end

  // big-endian lane selection on the read word: extract for loads, merge for sub-word stores
  always_comb begin
    lane_half   = addr_q[1] ? bus.Mem_Data[15:0] : bus.Mem_Data[31:16];
    merged_half = addr_q[1] ? {bus.Mem_Data[31:16], wdata_q[15:0]}
                            : {wdata_q[15:0], bus.Mem_Data[15:0]};
    lane_byte   = bus.Mem_Data[31:24];
    merged_byte = {wdata_q[7:0], bus.Mem_Data[23:0]};
    case (addr_q[1:0])
      2'd0: begin
        lane_byte   = bus.Mem_Data[31:24];
        merged_byte = {wdata_q[7:0], bus.Mem_Data[23:0]};
      end
      2'd1: begin
        lane_byte   = bus.Mem_Data[23:16];
        merged_byte = {bus.Mem_Data[31:24], wdata_q[7:0], bus.Mem_Data[15:0]};
      end
      2'd2: begin
        lane_byte   = bus.Mem_Data[15:8];
        merged_byte = {bus.Mem_Data[31:16], wdata_q[7:0], bus.Mem_Data[7:0]};
      end
      default: begin
        lane_byte   = bus.Mem_Data[7:0];
        merged_byte = {bus.Mem_Data[31:8], wdata_q[7:0]};
      end
    endcase
    case (size_q)
      SZ_BYTE: begin
        load_ext = uns_q ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        merged   = merged_byte;
      end
      SZ_HALF: begin
        load_ext = uns_q ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
        merged   = merged_half;
      end
      default: begin
        load_ext = bus.Mem_Data;
        merged   = wdata_q;
      end
    endcase
  end

  // state and captured request; async reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // next state, request capture at accept, response data at entry to RESP
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (req_err) begin
            rdata_d = 32'd0;
            error_d = 1'b1;
            state_d = S_RESP;
          end else if (!bus.req_write) begin
            state_d = S_RD;
          end else if (bus.req_size == SZ_WORD) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (write_q) begin
          wdata_d = merged;
          state_d = S_WR;
        end else begin
          rdata_d = load_ext;
          error_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        rdata_d = 32'd0;
        error_d = 1'b0;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // bus strobes decoded straight from the state register so reset drops them at once
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.rsp_valid  = (state_q == S_RESP);
    bus.rsp_rdata  = rdata_q;
    bus.rsp_error  = error_q;
    bus.Mem_Read   = (state_q == S_RD);
    bus.Mem_Write  = (state_q == S_WR);
    bus.Address    = ((state_q == S_RD) || (state_q == S_WR)) ? {addr_q[31:2], 2'b00} : 32'd0;
    bus.Write_data = (state_q == S_WR) ? wdata_q : 32'd0;
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb/tb_data_mem_access_unit.sv - directed self-checking bench for data_mem_access_unit
module tb_data_mem_access_unit;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  data_mem_access_unit_if bus ();

  data_mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: combinational big-endian read, write on rising edge
  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  always_comb begin
    ma = bus.Address[9:0];
    bus.Mem_Data = {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]};
  end
  always @(posedge clk) begin
    if (bus.Mem_Write) begin
      mem[ma]         <= bus.Write_data[31:24];
      mem[ma + 10'd1] <= bus.Write_data[23:16];
      mem[ma + 10'd2] <= bus.Write_data[15:8];
      mem[ma + 10'd3] <= bus.Write_data[7:0];
    end
  end

  // presents one request, then records what happens on the bus until the response
  task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] rd_addr, output logic [31:0] wr_addr,
                         output logic [31:0] wr_data, output logic [31:0] rdata,
                         output logic err);
    lat = 0; nrd = 0; nwr = 0;
    rd_addr = 32'hX; wr_addr = 32'hX; wr_data = 32'hX; rdata = 32'hX; err = 1'bX;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_size = 2'b11;
    bus.req_unsigned = ~u; bus.req_addr = 32'h0000_0001; bus.req_wdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.Mem_Read)  begin nrd++; rd_addr = bus.Address; end
      if (bus.Mem_Write) begin nwr++; wr_addr = bus.Address; wr_data = bus.Write_data; end
      if (bus.rsp_valid) begin lat = c; rdata = bus.rsp_rdata; err = bus.rsp_error; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    #3;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    n_cmp++; if (bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error got %b exp 0", bus.rsp_error); end
    n_cmp++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
    n_cmp++; if (bus.Mem_Read !== 1'b0 || bus.Mem_Write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got %b%b exp 00", bus.Mem_Read, bus.Mem_Write); end
    n_cmp++; if (bus.Address !== 32'd0 || bus.Write_data !== 32'd0) begin n_fail++; $display("FAIL reset_bus got %h/%h exp 0/0", bus.Address, bus.Write_data); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_word();
    int lat, nrd, nwr; logic [31:0] ra, wa, wdat, rd; logic e;
    run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d exp 2", lat); end
    n_cmp++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL lw_strobes got rd=%0d wr=%0d exp 1/0", nrd, nwr); end
    n_cmp++; if (ra !== 32'h30) begin n_fail++; $display("FAIL lw_address got %h exp 00000030", ra); end
    n_cmp++; if (rd !== 32'h0000_0004 || e !== 1'b0) begin n_fail++; $display("FAIL lw_data got %h err=%b exp 00000004 err=0", rd, e); end
  endtask

  task automatic test_load_subword();
    int lat, nrd, nwr; logic [31:0] ra, wa, wdat, rd; logic e;
    run_req(1'b0, 2'b00, 1'b0, 32'h1C, 32'd0, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (rd !== 32'hFFFF_FFAC || lat !== 2 || ra !== 32'h1C) begin n_fail++; $display("FAIL lb got %h lat=%0d addr=%h exp ffffffac lat=2 addr=1c", rd, lat, ra); end
    run_req(1'b0, 2'b00, 1'b1, 32'h1C, 32'd0, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (rd !== 32'h0000_00AC) begin n_fail++; $display("FAIL lbu got %h exp 000000ac", rd); end
    @(negedge clk); @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0000_00AC) begin n_fail++; $display("FAIL rsp_hold got valid=%b data=%h exp 0/000000ac", bus.rsp_valid, bus.rsp_rdata); end
    run_req(1'b0, 2'b01, 1'b0, 32'h1C, 32'd0, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (rd !== 32'hFFFF_AC09) begin n_fail++; $display("FAIL lh got %h exp ffffac09", rd); end
    run_req(1'b0, 2'b00, 1'b0, 32'h33, 32'd0, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (rd !== 32'h0000_0004 || ra !== 32'h30) begin n_fail++; $display("FAIL lb_lane3 got %h addr=%h exp 00000004 addr=30", rd, ra); end
  endtask

  task automatic test_store_subword();
    int lat, nrd, nwr; logic [31:0] ra, wa, wdat, rd; logic e;
    run_req(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_0055, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sb_latency got %0d exp 3", lat); end
    n_cmp++; if (nrd !== 1 || nwr !== 1 || ra !== 32'h30 || wa !== 32'h30) begin n_fail++; $display("FAIL sb_bus got rd=%0d wr=%0d ra=%h wa=%h exp 1/1/30/30", nrd, nwr, ra, wa); end
    n_cmp++; if (wdat !== 32'h0055_0004) begin n_fail++; $display("FAIL sb_merge got %h exp 00550004", wdat); end
    n_cmp++; if (rd !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL sb_rsp got %h err=%b exp 0/0", rd, e); end
    run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'd0, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (rd !== 32'h0055_0004) begin n_fail++; $display("FAIL sb_readback got %h exp 00550004", rd); end
    run_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h1234_BEEF, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (wdat !== 32'h0055_BEEF || lat !== 3) begin n_fail++; $display("FAIL sh_merge got %h lat=%0d exp 0055beef lat=3", wdat, lat); end
  endtask

  task automatic test_store_word();
    int lat, nrd, nwr; logic [31:0] ra, wa, wdat, rd; logic e;
    run_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFE_F00D, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (lat !== 2 || nrd !== 0 || nwr !== 1) begin n_fail++; $display("FAIL sw_flow got lat=%0d rd=%0d wr=%0d exp 2/0/1", lat, nrd, nwr); end
    n_cmp++; if (wa !== 32'h3FC || wdat !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL sw_bus got %h/%h exp 000003fc/cafef00d", wa, wdat); end
    run_req(1'b0, 2'b01, 1'b0, 32'h3FE, 32'd0, lat, nrd, nwr, ra, wa, wdat, rd, e);
    n_cmp++; if (rd !== 32'hFFFF_F00D || e !== 1'b0) begin n_fail++; $display("FAIL lh_top got %h err=%b exp fffff00d err=0", rd, e); end
  endtask

  task automatic test_errors();
    int lat, nrd, nwr; logic [31:0] ra, wa, wdat, rd; logic e;
    logic        t_w  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  t_sz [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [31:0] t_a  [5] = '{32'h33, 32'h3FE, 32'h30, 32'h400, 32'h3FF};
    for (int i = 0; i < 5; i++) begin
      run_req(t_w[i], t_sz[i], 1'b0, t_a[i], 32'h1111_1111, lat, nrd, nwr, ra, wa, wdat, rd, e);
      n_cmp++;
      if (lat !== 1 || e !== 1'b1 || rd !== 32'd0 || nrd !== 0 || nwr !== 0) begin
        n_fail++;
        $display("FAIL err_case%0d got lat=%0d err=%b data=%h rd=%0d wr=%0d exp 1/1/0/0/0", i, lat, e, rd, nrd, nwr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  t_sz [3] = '{2'b10, 2'b00, 2'b01};
    logic        t_u  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] t_a  [3] = '{32'h30, 32'h1C, 32'h32};
    logic [31:0] t_exp[3] = '{32'h0055_BEEF, 32'h0000_00AC, 32'hFFFF_BEEF};
    logic [31:0] got  [3];
    int acc_cyc [3];
    int acc, nrsp, bad;
    logic fire;
    acc = 0; nrsp = 0; bad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = t_sz[0];
    bus.req_unsigned = t_u[0]; bus.req_addr = t_a[0];
    for (int c = 0; c < 30 && nrsp < 3; c++) begin
      if (bus.rsp_valid) begin
        if (nrsp < 3) got[nrsp] = bus.rsp_rdata;
        nrsp++;
      end
      if (bus.req_ready && (bus.Mem_Read || bus.Mem_Write || bus.rsp_valid)) bad++;
      fire = bus.req_ready && bus.req_valid;
      @(posedge clk);
      if (fire) begin
        if (acc < 3) acc_cyc[acc] = c;
        acc++;
        #1;
        if (acc < 3) begin
          bus.req_size = t_sz[acc]; bus.req_unsigned = t_u[acc]; bus.req_addr = t_a[acc];
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_cmp++; if (acc !== 3 || nrsp !== 3) begin n_fail++; $display("FAIL b2b_count got acc=%0d rsp=%0d exp 3/3", acc, nrsp); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_overlap got %0d exp 0", bad); end
    if (acc == 3) begin
      n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin n_fail++; $display("FAIL b2b_spacing got %0d,%0d exp 3,3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
    end
    if (nrsp == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (got[i] !== t_exp[i]) begin n_fail++; $display("FAIL b2b_data%0d got %h exp %h", i, got[i], t_exp[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int highs;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'h1122_3344;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.Mem_Write !== 1'b1 || bus.Address !== 32'h40) begin n_fail++; $display("FAIL rst_wr_cycle got wr=%b addr=%h exp 1/00000040", bus.Mem_Write, bus.Address); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.Mem_Write !== 1'b0 || bus.Write_data !== 32'd0) begin n_fail++; $display("FAIL rst_drop got wr=%b data=%h exp 0/0", bus.Mem_Write, bus.Write_data); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({mem[10'h40], mem[10'h41], mem[10'h42], mem[10'h43]} !== 32'd0) begin n_fail++; $display("FAIL rst_mem got %h exp 0", {mem[10'h40], mem[10'h41], mem[10'h42], mem[10'h43]}); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release got ready=%b valid=%b exp 1/0", bus.req_ready, bus.rsp_valid); end
    highs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) highs++;
    end
    n_cmp++; if (highs !== 0) begin n_fail++; $display("FAIL rst_no_rsp got %0d exp 0", highs); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h33] = 8'h04;
    mem[10'h1C] = 8'hAC;
    mem[10'h1D] = 8'h09;
    test_reset();
    test_load_word();
    test_load_subword();
    test_store_subword();
    test_store_word();
    test_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
